sparse_mvm_core: RTL and testbench
==================================

# sparse_mvm_core

Parametrised sparsity-aware matrix-vector multiply engine. The host loads a dense N-element vector and then streams only the nonzero matrix entries as (row, col, value) triples. The core accumulates one product per accepted entry into per-row accumulators, then drains the result vector over a valid/ready port. Optionally, rows that received no nonzero entry are skipped on drain. It sits between the chip I/O adapter and the host-side CPU link, and generalises the fixed 8-bit, 4×4 engine to configurable dimension, data width and drain mode.

## Interface
- N, 4: vector length and matrix dimension; legal range 2..16. IDX_W = max(1, clog2(N)).
- DATA_W, 8: signed two's-complement width of vector and matrix values.
- ACC_W, 2*DATA_W+clog2(N): signed accumulator and output width; must be ≥ 2*DATA_W.
- SKIP_ZERO_ROWS, 0: 1 = drain emits only rows hit by a nonzero entry; 0 = drain emits all N rows.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; honoured in IDLE only.
- in_valid  in  1  input triple valid.
- in_ready  out  1  core accepts the triple this cycle.
- in_kind  in  1  0 = vector element, 1 = matrix element.
- in_row  in  IDX_W  matrix row; ignored for vector elements.
- in_col  in  IDX_W  vector index / matrix column.
- in_data  in  DATA_W  signed value.
- in_last  in  1  marks the final triple of the current phase.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  IDX_W  row index of out_data.
- out_data  out  ACC_W  signed row result.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky: an index ≥ N, or a wrong in_kind for the phase, was received; cleared by start.

## Operation
- States: IDLE → LOAD_VEC → LOAD_MAT → DRAIN → IDLE.
- **IDLE**
  - start=1: clear vec[], acc[], hit[] and err; go to LOAD_VEC.
  - in_ready=0, out_valid=0.
- **LOAD_VEC**
  - in_ready=1. Accept = in_valid & in_ready.
  - On accept with in_kind=0 and in_col<N: vec[in_col] ← in_data. Rewriting an index overwrites it; unloaded entries stay 0.
  - Accepted triple with in_kind=1 or in_col≥N: dropped, err←1.
  - Accept with in_last=1: go to LOAD_MAT.
- **LOAD_MAT**
  - in_ready=1.
  - On accept with in_kind=1 and both indices <N: acc[in_row] ← acc[in_row] + sext(in_data*vec[in_col]).
    - Full-precision signed product; accumulation wraps modulo 2^ACC_W with no saturation.
    - Duplicate (row, col) entries accumulate.
    - in_data≠0 also sets hit[in_row]. A zero-valued entry is accumulated but does not set hit.
  - Invalid kind or index: dropped, err←1.
  - Accept with in_last=1: go to DRAIN. The last entry is included in the result.
- **DRAIN**
  - in_ready=0.
  - Eligible rows: all rows when SKIP_ZERO_ROWS=0; otherwise rows with hit=1.
  - Rows are emitted in ascending index order. out_valid=1 with out_idx = lowest remaining eligible row and out_data = acc[out_idx].
  - out_valid & out_ready: advance to the next eligible row, one row per cycle at most.
  - After the final handshake: done=1 for one cycle, go to IDLE.
  - No eligible rows (SKIP mode, nothing hit): out_valid never rises; done pulses on the first DRAIN cycle; go to IDLE.
- start is ignored in every state except IDLE.
- Results remain in acc[] after the job until the next start.

## Timing
- Reset values: state=IDLE; all arrays=0; in_ready=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, err=0.
- Reset acts immediately and asynchronously in any state, aborting the job. The first start after reset begins a clean job.
- start at edge t → busy=1 and in_ready=1 from t+1.
- in_ready is a function of state only. No stalls occur within a load phase, so the core sustains one triple per cycle.
- A matrix entry accepted at edge t updates acc at t. A vector write at t is usable by a matrix entry at t+1.
- in_last accepted in LOAD_MAT at edge t → out_valid=1 at t+1, first eligible row registered.
- While out_valid=1 and out_ready=0: out_idx and out_data are held stable.
- done asserts in the cycle after the last drain handshake, and busy drops in that same cycle.
- err rises the cycle after the offending accept.

## Test plan
- **Dense identity:** N=4, DATA_W=8, vec=[1,2,3,4], entries (r,r,2) for r=0..3, out_ready=1 → out (0,2),(1,4),(2,6),(3,8) on 4 consecutive cycles, then done for 1 cycle.
- **Sparse skip:** SKIP_ZERO_ROWS=1, vec[1]=3, single entry (2,1,5) with last → exactly one output (2,15), then done. Same stimulus with SKIP_ZERO_ROWS=0 → rows 0,1,3 = 0 and row 2 = 15.
- **Signed / duplicates:** vec[0]=-128, entries (0,0,-128)×2 → out_data[0] = 32768. Entry (1,0,127) → row1 = -16256. A zero entry (3,0,0) in SKIP mode emits no row 3.
- **Backpressure:** dense case with out_ready low for 3 cycles on row 1 → out_idx=1 and out_data=4 held unchanged; row 2 follows the cycle after out_ready rises.
- **Error / start ignore:** in_col=5 with N=4 → err=1 and vec unchanged. start pulsed during LOAD_MAT → ignored. The next job's start clears err.
- **Reset mid-job:** assert rst_n=0 during LOAD_MAT after 2 entries → all outputs reach reset values immediately. A new job after reset yields results with no residue from the aborted one.

Source files
------------

// File: rtl/sparse_mvm_core.sv
// sparse_mvm_core: sparsity-aware matrix-vector multiply engine.
// Loads a dense vector, accumulates products of streamed nonzero matrix
// entries into per-row accumulators, then drains the rows over valid/ready.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. in_ready depends on state only, so the producer may hold
// in_valid without waiting for it. While out_valid is high and out_ready is
// low, out_idx and out_data stay stable, and out_valid never drops until the
// row has been taken.
module sparse_mvm_core #(
  parameter int N              = 4,
  parameter int DATA_W         = 8,
  parameter int ACC_W          = 2 * DATA_W + $clog2(N),
  parameter bit SKIP_ZERO_ROWS = 1'b0,
  localparam int IDX_W         = (N > 2) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_kind,
  input  logic [IDX_W-1:0]         in_row,
  input  logic [IDX_W-1:0]         in_col,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_VEC = 2'd1,
    S_LOAD_MAT = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  localparam int IDX_SPAN = 2 ** IDX_W;

  // Lookup of which encodable index values address a real row/column.
  function automatic logic [IDX_SPAN-1:0] idx_ok_map();
    logic [IDX_SPAN-1:0] m;
    m = '0;
    for (int i = 0; i < IDX_SPAN; i++) begin
      m[i] = (i < N);
    end
    return m;
  endfunction

  localparam logic [IDX_SPAN-1:0] IDX_OK = idx_ok_map();

  // Rows taking part in the drain, given the hit mask.
  function automatic logic [N-1:0] elig_mask(input logic [N-1:0] hit);
    return SKIP_ZERO_ROWS ? hit : {N{1'b1}};
  endfunction

  // Lowest set bit of mask at or above 'from'; MSB of result = found.
  function automatic logic [IDX_W:0] first_eligible(input logic [N-1:0] mask, input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  state_t                     state_q, state_d;
  logic signed [DATA_W-1:0]   vec_q [N];
  logic signed [DATA_W-1:0]   vec_d [N];
  logic signed [ACC_W-1:0]    acc_q [N];
  logic signed [ACC_W-1:0]    acc_d [N];
  logic [N-1:0]               hit_q, hit_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       out_valid_q, out_valid_d;
  logic [IDX_W-1:0]           out_idx_q, out_idx_d;

  logic                       accept;
  logic                       row_ok, col_ok;
  logic [IDX_W-1:0]           row_s, col_s;
  logic                       mat_ok;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_add;
  logic [N-1:0]               hit_next;
  logic [IDX_W:0]             first_res;
  logic [IDX_W:0]             next_res;

  assign accept = in_valid & in_ready;
  assign row_ok = IDX_OK[in_row];
  assign col_ok = IDX_OK[in_col];
  assign row_s  = row_ok ? in_row : '0;
  assign col_s  = col_ok ? in_col : '0;
  assign mat_ok = in_kind & row_ok & col_ok;

  // Full-precision signed product, sign-extended to the accumulator width.
  assign prod    = (2 * DATA_W)'(in_data) * (2 * DATA_W)'(vec_q[col_s]);
  assign acc_add = ACC_W'(prod);

  // Hit mask including the entry accepted this cycle, so the drain start
  // sees a last entry that is the only hit.
  assign hit_next = (accept && (state_q == S_LOAD_MAT) && mat_ok && (in_data != '0))
                    ? (hit_q | (N'(1) << row_s)) : hit_q;

  assign first_res = first_eligible(elig_mask(hit_next), 0);
  assign next_res  = first_eligible(elig_mask(hit_q), int'(out_idx_q) + 1);

  // Next-state, array updates and drain sequencing.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    acc_d       = acc_q;
    hit_d       = hit_q;
    err_d       = err_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N; i++) begin
            vec_d[i] = '0;
            acc_d[i] = '0;
          end
          hit_d       = '0;
          err_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_LOAD_VEC;
        end
      end
      S_LOAD_VEC: begin
        if (accept) begin
          if (!in_kind && col_ok) begin
            vec_d[col_s] = in_data;
          end else begin
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = S_LOAD_MAT;
          end
        end
      end
      S_LOAD_MAT: begin
        if (accept) begin
          if (mat_ok) begin
            acc_d[row_s] = acc_q[row_s] + acc_add;
          end else begin
            err_d = 1'b1;
          end
          hit_d = hit_next;
          if (in_last) begin
            state_d     = S_DRAIN;
            out_valid_d = first_res[IDX_W];
            out_idx_d   = first_res[IDX_W] ? first_res[IDX_W-1:0] : '0;
            // Nothing to emit: report completion during the single DRAIN cycle.
            done_d      = !first_res[IDX_W];
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (next_res[IDX_W]) begin
            out_idx_d = next_res[IDX_W-1:0];
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= '0;
        acc_q[i] <= '0;
      end
      hit_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= vec_d[i];
        acc_q[i] <= acc_d[i];
      end
      hit_q       <= hit_d;
      err_q       <= err_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD_VEC) || (state_q == S_LOAD_MAT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_valid_q ? acc_q[out_idx_q] : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sparse_mvm_core.sv
// Bench for sparse_mvm_core: three instances (N=4 dense drain, N=4 skip
// drain, N=6 skip drain) share one input bus; only the started instance
// consumes it. Directed table cases, hand-written corner sequences and
// randomized jobs checked against a plain arithmetic model.
module tb_sparse_mvm_core;

  typedef struct packed {
    logic               kind;
    logic [3:0]         row;
    logic [3:0]         col;
    logic signed [7:0]  data;
  } trip_t;

  typedef struct {
    int    sel;
    int    nv;
    trip_t v [4];
    int    nm;
    trip_t m [4];
    int    en;
    int    ei [4];
    int    ed [4];
    bit    ee;
  } case_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared input bus
  logic [2:0]        start = '0;
  logic              in_valid = 1'b0;
  logic              in_kind = 1'b0;
  logic [3:0]        in_row = '0;
  logic [3:0]        in_col = '0;
  logic signed [7:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;

  // Per-instance outputs
  logic               o_rdy   [3];
  logic               o_valid [3];
  logic               o_busy  [3];
  logic               o_done  [3];
  logic               o_err   [3];
  logic [3:0]         o_idx   [3];
  logic signed [31:0] o_data  [3];
  logic [1:0]         o_dbg   [3];

  logic [1:0]         d0_idx, d1_idx;
  logic [2:0]         d2_idx;
  logic signed [17:0] d0_data, d1_data;
  logic signed [18:0] d2_data;

  sparse_mvm_core #(.N(4), .DATA_W(8), .SKIP_ZERO_ROWS(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .in_kind(in_kind), .in_row(in_row[1:0]), .in_col(in_col[1:0]), .in_data(in_data),
    .in_last(in_last), .out_valid(o_valid[0]), .out_ready(out_ready), .out_idx(d0_idx),
    .out_data(d0_data), .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .dbg_state(o_dbg[0]));

  sparse_mvm_core #(.N(4), .DATA_W(8), .SKIP_ZERO_ROWS(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .in_kind(in_kind), .in_row(in_row[1:0]), .in_col(in_col[1:0]), .in_data(in_data),
    .in_last(in_last), .out_valid(o_valid[1]), .out_ready(out_ready), .out_idx(d1_idx),
    .out_data(d1_data), .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .dbg_state(o_dbg[1]));

  sparse_mvm_core #(.N(6), .DATA_W(8), .SKIP_ZERO_ROWS(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .in_kind(in_kind), .in_row(in_row[2:0]), .in_col(in_col[2:0]), .in_data(in_data),
    .in_last(in_last), .out_valid(o_valid[2]), .out_ready(out_ready), .out_idx(d2_idx),
    .out_data(d2_data), .busy(o_busy[2]), .done(o_done[2]), .err(o_err[2]), .dbg_state(o_dbg[2]));

  assign o_idx[0]  = {2'b00, d0_idx};
  assign o_idx[1]  = {2'b00, d1_idx};
  assign o_idx[2]  = {1'b0, d2_idx};
  assign o_data[0] = {{14{d0_data[17]}}, d0_data};
  assign o_data[1] = {{14{d1_data[17]}}, d1_data};
  assign o_data[2] = {{13{d2_data[18]}}, d2_data};

  // Scoreboard state
  int          checks = 0;
  int          failures = 0;
  logic [35:0] exp_q [$];
  bit          exp_err;
  trip_t       vq [$];
  trip_t       mq [$];
  case_t       tc [7];

  function automatic int n_of(input int sel);
    return (sel == 2) ? 6 : 4;
  endfunction
  function automatic bit skip_of(input int sel);
    return (sel != 0);
  endfunction
  function automatic int aw_of(input int sel);
    return (sel == 2) ? 19 : 18;
  endfunction
  function automatic int iw_of(input int sel);
    return (sel == 2) ? 3 : 2;
  endfunction

  function automatic trip_t T(input int k, input int r, input int c, input int d);
    trip_t x;
    x.kind = k[0];
    x.row  = r[3:0];
    x.col  = c[3:0];
    x.data = d[7:0];
    return x;
  endfunction

  function automatic logic [31:0] wrap_acc(input longint v, input int aw);
    longint m;
    m = v & ((longint'(1) << aw) - 1);
    if (m >= (longint'(1) << (aw - 1))) m = m - (longint'(1) << aw);
    return m[31:0];
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: dense vector, per-row sums, drain list in row order.
  task automatic build_exp(input int sel);
    longint vec [16];
    longint acc [16];
    bit     hit [16];
    int     n;
    trip_t  x;
    n = n_of(sel);
    for (int i = 0; i < 16; i++) begin
      vec[i] = 0;
      acc[i] = 0;
      hit[i] = 0;
    end
    exp_err = 0;
    exp_q.delete();
    foreach (vq[i]) begin
      x = vq[i];
      if (!x.kind && (int'(x.col) < n)) vec[x.col] = longint'($signed(x.data));
      else exp_err = 1;
    end
    foreach (mq[i]) begin
      x = mq[i];
      if (x.kind && (int'(x.row) < n) && (int'(x.col) < n)) begin
        acc[x.row] = acc[x.row] + longint'($signed(x.data)) * vec[x.col];
        if (x.data != 0) hit[x.row] = 1;
      end else begin
        exp_err = 1;
      end
    end
    for (int r = 0; r < n; r++) begin
      if (!skip_of(sel) || hit[r]) exp_q.push_back({4'(r), wrap_acc(acc[r], aw_of(sel))});
    end
  endtask

  task automatic load_case(input int c);
    vq.delete();
    mq.delete();
    exp_q.delete();
    for (int k = 0; k < tc[c].nv; k++) vq.push_back(tc[c].v[k]);
    for (int k = 0; k < tc[c].nm; k++) mq.push_back(tc[c].m[k]);
    for (int k = 0; k < tc[c].en; k++) exp_q.push_back({4'(tc[c].ei[k]), 32'(tc[c].ed[k])});
    exp_err = tc[c].ee;
  endtask

  // Driver: present one triple, then advance to the next falling edge.
  task automatic drive(input trip_t x, input bit last);
    in_valid = 1'b1;
    in_kind  = x.kind;
    in_row   = x.row;
    in_col   = x.col;
    in_data  = x.data;
    in_last  = last;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_kind  = 1'b0;
  endtask

  // One full job: start, vector phase, matrix phase, checked drain.
  // bp: 0 = always ready, 1 = random ready, 2 = hold row 1 for 3 cycles.
  task automatic run_job(input int sel, input int bp, input bit mid_start);
    int          cyc;
    int          hold;
    int          nrows;
    logic [35:0] f;
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    chk("start_busy", o_busy[sel], 1);
    chk("start_in_ready", o_rdy[sel], 1);
    chk("start_err_clear", o_err[sel], 0);
    foreach (vq[i]) drive(vq[i], i == vq.size() - 1);
    foreach (mq[i]) begin
      if (mid_start && i == 0) start[sel] = 1'b1;
      drive(mq[i], i == mq.size() - 1);
      start[sel] = 1'b0;
    end
    idle_inputs();
    nrows = exp_q.size();
    cyc = 0;
    hold = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      chk("drain_valid", o_valid[sel], 1);
      chk("drain_in_ready", o_rdy[sel], 0);
      f = exp_q[0];
      if (o_valid[sel]) begin
        chk("drain_idx", o_idx[sel], f[35:32]);
        chk("drain_data", o_data[sel], $signed(f[31:0]));
      end
      if (bp == 1) out_ready = ($urandom_range(0, 3) != 0);
      else if (bp == 2 && f[35:32] == 4'd1 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else out_ready = 1'b1;
      if (out_ready && o_valid[sel]) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    out_ready = 1'b0;
    chk("done_pulse", o_done[sel], 1);
    chk("done_out_valid", o_valid[sel], 0);
    chk("done_busy", o_busy[sel], (nrows == 0) ? 1 : 0);
    chk("job_err", o_err[sel], exp_err);
    @(negedge clk);
    chk("done_clear", o_done[sel], 0);
    chk("idle_busy", o_busy[sel], 0);
    chk("idle_in_ready", o_rdy[sel], 0);
    chk("idle_state", o_dbg[sel], 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    trip_t x;
    int    sel, nv, nm, iw;
    bit    heavy;

    // Directed table: {instance, vector triples, matrix triples, expected rows, expected err}
    tc[0] = '{0, 4, '{T(0,0,0,1), T(0,0,1,2), T(0,0,2,3), T(0,0,3,4)},
              4, '{T(1,0,0,2), T(1,1,1,2), T(1,2,2,2), T(1,3,3,2)},
              4, '{0,1,2,3}, '{2,4,6,8}, 1'b0};
    tc[1] = '{1, 1, '{T(0,0,1,3), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              1, '{T(1,2,1,5), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              1, '{2,0,0,0}, '{15,0,0,0}, 1'b0};
    tc[2] = '{0, 1, '{T(0,0,1,3), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              1, '{T(1,2,1,5), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              4, '{0,1,2,3}, '{0,0,15,0}, 1'b0};
    tc[3] = '{1, 1, '{T(0,0,0,-128), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              4, '{T(1,0,0,-128), T(1,0,0,-128), T(1,1,0,127), T(1,3,0,0)},
              2, '{0,1,0,0}, '{32768,-16256,0,0}, 1'b0};
    tc[4] = '{0, 2, '{T(0,0,1,7), T(1,0,1,9), T(0,0,0,0), T(0,0,0,0)},
              2, '{T(1,0,1,2), T(0,2,1,3), T(0,0,0,0), T(0,0,0,0)},
              4, '{0,1,2,3}, '{14,0,0,0}, 1'b1};
    tc[5] = '{2, 2, '{T(0,0,2,4), T(0,0,7,9), T(0,0,0,0), T(0,0,0,0)},
              4, '{T(1,6,2,3), T(1,5,2,-3), T(1,1,6,5), T(1,1,2,2)},
              2, '{1,5,0,0}, '{8,-12,0,0}, 1'b1};
    tc[6] = '{1, 1, '{T(0,0,0,1), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              1, '{T(1,2,0,0), T(0,0,0,0), T(0,0,0,0), T(0,0,0,0)},
              0, '{0,0,0,0}, '{0,0,0,0}, 1'b0};

    // Reset values
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_in_ready", o_rdy[s], 0);
      chk("rst_out_valid", o_valid[s], 0);
      chk("rst_out_idx", o_idx[s], 0);
      chk("rst_out_data", o_data[s], 0);
      chk("rst_busy", o_busy[s], 0);
      chk("rst_done", o_done[s], 0);
      chk("rst_err", o_err[s], 0);
      chk("rst_state", o_dbg[s], 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int c = 0; c < 7; c++) begin
      load_case(c);
      run_job(tc[c].sel, 0, 1'b0);
    end

    // Backpressure on row 1 of the dense case
    load_case(0);
    run_job(0, 2, 1'b0);

    // start during LOAD_MAT is ignored: err from the vector phase survives
    load_case(4);
    run_job(0, 0, 1'b1);

    // Reset in the middle of LOAD_MAT
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    drive(T(1,0,0,5), 1'b0);
    chk("err_rise", o_err[0], 1);
    drive(T(0,0,0,3), 1'b1);
    drive(T(1,0,0,2), 1'b0);
    drive(T(1,1,0,4), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", o_rdy[0], 0);
    chk("abort_out_valid", o_valid[0], 0);
    chk("abort_out_idx", o_idx[0], 0);
    chk("abort_out_data", o_data[0], 0);
    chk("abort_busy", o_busy[0], 0);
    chk("abort_done", o_done[0], 0);
    chk("abort_err", o_err[0], 0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vq.delete();
    mq.delete();
    vq.push_back(T(0,0,0,1));
    mq.push_back(T(1,3,0,5));
    build_exp(0);
    run_job(0, 0, 1'b0);

    // Randomized jobs against the model
    for (int j = 0; j < 40; j++) begin
      sel   = $urandom_range(0, 2);
      iw    = iw_of(sel);
      heavy = ($urandom_range(0, 4) == 0);
      nv    = $urandom_range(1, 6);
      nm    = heavy ? $urandom_range(8, 14) : $urandom_range(1, 12);
      vq.delete();
      mq.delete();
      if (heavy) vq.push_back(T(0, 0, 0, -128));
      else begin
        for (int k = 0; k < nv; k++) begin
          x.kind = ($urandom_range(0, 9) == 0);
          x.row  = 4'($urandom_range(0, 15));
          x.col  = 4'($urandom_range(0, (1 << iw) - 1));
          x.data = 8'($urandom_range(0, 255));
          vq.push_back(x);
        end
      end
      for (int k = 0; k < nm; k++) begin
        if (heavy) x = T(1, 0, 0, ($urandom_range(0, 3) == 0) ? 127 : -128);
        else begin
          x.kind = ($urandom_range(0, 9) != 0);
          x.row  = 4'($urandom_range(0, (1 << iw) - 1));
          x.col  = 4'($urandom_range(0, (1 << iw) - 1));
          x.data = ($urandom_range(0, 5) == 0) ? 8'sd0 : 8'($urandom_range(0, 255));
        end
        mq.push_back(x);
      end
      build_exp(sel);
      run_job(sel, 1, ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
